multi_display_timer: RTL and testbench

MULTI_DISPLAY_TIMER -- requirements
Module: multi_display_timer

---
 rtl/display_timer_pkg.sv | 17 +
 rtl/display_timer_ch.sv | 111 +++++++++++
 rtl/multi_display_timer.sv | 46 ++++
 tb/tb_multi_display_timer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/display_timer_pkg.sv
// Shared definitions for the display timer channels: channel state
// encoding, default on-time and the width of the holdoff counter.
package display_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } timer_state_t;

    // Default on-time in clk cycles (fits the default 29-bit counter).
    localparam int unsigned DEFAULT_DURATION = 350_000_000;

    // Holdoff counter width; HOLDOFF is limited to 0..255.
    localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/display_timer_ch.sv
// One display timer channel: synchronous rising-edge detector on trigger,
// IDLE/ACTIVE/HOLD FSM, on-time down-counter and post-expiry holdoff.
module display_timer_ch
    import display_timer_pkg::*;
#(
    parameter int unsigned CNT_W   = 29,
    parameter int unsigned HOLDOFF = 0,
    parameter int unsigned RETRIG  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             cancel,
    input  logic [CNT_W-1:0] duration,
    output logic             display_enable,
    output logic             done
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;
    localparam bit RETRIG_EN = (RETRIG != 0);
    localparam bit HOLD_EN   = (HOLDOFF > 0);

    timer_state_t      state, state_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              trig_d;
    logic              trig_edge;
    logic              enable_n;
    logic              done_n;
    logic [CNT_W-1:0]  reload;

    assign trig_edge = trigger & ~trig_d;

    // A zero duration still yields one enabled cycle, so load max(d,1)-1.
    assign reload = (duration == '0) ? '0 : duration - CNT_W'(1);

    // Next-state logic; cancel overrides trigger, retrigger and expiry.
    always_comb begin
        state_n  = state;
        count_n  = count;
        hold_n   = hold_cnt;
        enable_n = display_enable;
        done_n   = 1'b0;
        if (cancel) begin
            state_n  = IDLE;
            count_n  = '0;
            hold_n   = '0;
            enable_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        state_n  = ACTIVE;
                        count_n  = reload;
                        enable_n = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (trig_edge && RETRIG_EN) begin
                        count_n = reload;
                    end else if (count == '0) begin
                        enable_n = 1'b0;
                        done_n   = 1'b1;
                        if (HOLD_EN) begin
                            state_n = HOLD;
                            hold_n  = HOLD_LOAD;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        count_n = count - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state_n = IDLE;
                    end else begin
                        hold_n = hold_cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state_n  = IDLE;
                    count_n  = '0;
                    hold_n   = '0;
                    enable_n = 1'b0;
                end
            endcase
        end
    end

    // Channel state registers; trigger history is kept even while cancelled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            hold_cnt       <= '0;
            trig_d         <= 1'b0;
            display_enable <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_n;
            count          <= count_n;
            hold_cnt       <= hold_n;
            trig_d         <= trigger;
            display_enable <= enable_n;
            done           <= done_n;
        end
    end

endmodule

// File: rtl/multi_display_timer.sv
// Bank of independent display timers sharing one duration input, plus a
// registered "any channel on" flag.
module multi_display_timer
    import display_timer_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 29,
    parameter int unsigned HOLDOFF  = 0,
    parameter int unsigned RETRIG   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] trigger,
    input  logic [CHANNELS-1:0] cancel,
    input  logic [CNT_W-1:0]    duration,
    output logic [CHANNELS-1:0] display_enable,
    output logic [CHANNELS-1:0] done,
    output logic                any_active
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        display_timer_ch #(
            .CNT_W   (CNT_W),
            .HOLDOFF (HOLDOFF),
            .RETRIG  (RETRIG)
        ) u_ch (
            .clk            (clk),
            .reset          (reset),
            .trigger        (trigger[g]),
            .cancel         (cancel[g]),
            .duration       (duration),
            .display_enable (display_enable[g]),
            .done           (done[g])
        );
    end

    // Summary flag lags the per-channel enables by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_active <= 1'b0;
        end else begin
            any_active <= |display_enable;
        end
    end

endmodule

// File: tb/tb_multi_display_timer.sv
// Directed bench for multi_display_timer: three instances (plain, retrigger,
// holdoff) share stimulus; per-cycle outputs are packed into 32-bit traces
// and compared with hand-computed windows.
module tb_multi_display_timer;

    logic       clk;
    logic       reset;
    logic [1:0] trigger;
    logic [1:0] cancel;
    logic [7:0] duration;

    logic [1:0] en_a, en_r, en_h;
    logic [1:0] dn_a, dn_r, dn_h;
    logic       any_a, any_r, any_h;

    int n_vec;
    int n_miss;

    // traces: bit c = output value in run cycle c
    logic [31:0] ea0, ea1, da0, da1, aa;
    logic [31:0] er0, er1, dr0, dr1, ar;
    logic [31:0] eh0, dh0;

    multi_display_timer #(.CHANNELS(2), .CNT_W(8), .HOLDOFF(0), .RETRIG(0)) dut_a (
        .clk(clk), .reset(reset), .trigger(trigger), .cancel(cancel),
        .duration(duration), .display_enable(en_a), .done(dn_a), .any_active(any_a)
    );

    multi_display_timer #(.CHANNELS(2), .CNT_W(8), .HOLDOFF(0), .RETRIG(1)) dut_r (
        .clk(clk), .reset(reset), .trigger(trigger), .cancel(cancel),
        .duration(duration), .display_enable(en_r), .done(dn_r), .any_active(any_r)
    );

    multi_display_timer #(.CHANNELS(2), .CNT_W(8), .HOLDOFF(3), .RETRIG(0)) dut_h (
        .clk(clk), .reset(reset), .trigger(trigger), .cancel(cancel),
        .duration(duration), .display_enable(en_h), .done(dn_h), .any_active(any_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply 32 cycles of per-channel trigger/cancel levels, record traces.
    task automatic run32(input logic [31:0] t0, input logic [31:0] t1,
                         input logic [31:0] c0, input logic [31:0] c1);
        ea0 = '0; ea1 = '0; da0 = '0; da1 = '0; aa = '0;
        er0 = '0; er1 = '0; dr0 = '0; dr1 = '0; ar = '0;
        eh0 = '0; dh0 = '0;
        for (int c = 0; c < 32; c++) begin
            ea0[c] = en_a[0]; ea1[c] = en_a[1]; da0[c] = dn_a[0]; da1[c] = dn_a[1]; aa[c] = any_a;
            er0[c] = en_r[0]; er1[c] = en_r[1]; dr0[c] = dn_r[0]; dr1[c] = dn_r[1]; ar[c] = any_r;
            eh0[c] = en_h[0]; dh0[c] = dn_h[0];
            trigger = {t1[c], t0[c]};
            cancel  = {c1[c], c0[c]};
            step();
        end
        trigger = '0;
        cancel  = '0;
        repeat (8) step();
    endtask

    initial begin
        int cnt_en;
        int cnt_dn;
        n_vec    = 0;
        n_miss   = 0;
        reset    = 1'b1;
        trigger  = '0;
        cancel   = '0;
        duration = 8'd5;

        // reset state
        repeat (3) step();
        check_vec("rst_en", {26'd0, en_a, en_r, en_h}, 32'd0);
        check_vec("rst_dn", {26'd0, dn_a, dn_r, dn_h}, 32'd0);
        check_vec("rst_any", {29'd0, any_a, any_r, any_h}, 32'd0);
        reset = 1'b0;
        repeat (4) step();

        // single shot, duration 5, rise in cycle 10
        duration = 8'd5;
        run32(32'h0000_0C00, '0, '0, '0);
        check_vec("single_en0", ea0, 32'h0000_F800);
        check_vec("single_done0", da0, 32'h0001_0000);
        check_vec("single_any", aa, 32'h0001_F000);
        check_vec("single_en1_idle", ea1, 32'h0000_0000);
        check_vec("single_en0_retrig_dut", er0, 32'h0000_F800);
        check_vec("single_en0_hold_dut", eh0, 32'h0000_F800);
        check_vec("single_done0_hold_dut", dh0, 32'h0001_0000);

        // retrigger: edges in cycles 10 and 13
        run32(32'h0000_2400, '0, '0, '0);
        check_vec("retrig_en0", er0, 32'h0007_F800);
        check_vec("retrig_done0", dr0, 32'h0008_0000);
        check_vec("retrig_any", ar, 32'h000F_F000);
        check_vec("noretrig_en0", ea0, 32'h0000_F800);
        check_vec("noretrig_done0", da0, 32'h0001_0000);

        // holdoff 3, duration 2: edges in cycles 10, 14, 17
        duration = 8'd2;
        run32(32'h0002_4400, '0, '0, '0);
        check_vec("holdoff_en0", eh0, 32'h000C_1800);
        check_vec("holdoff_done0", dh0, 32'h0010_2000);
        check_vec("noholdoff_en0", ea0, 32'h000D_9800);
        check_vec("noholdoff_done0", da0, 32'h0012_2000);

        // cancel and trigger edge together on channel 1 while active
        duration = 8'd5;
        run32('0, 32'h0000_1400, '0, 32'h0000_1000);
        check_vec("cancel_en1", ea1, 32'h0000_1800);
        check_vec("cancel_done1", da1, 32'h0000_0000);
        check_vec("cancel_any", aa, 32'h0000_3000);
        check_vec("cancel_en1_retrig_dut", er1, 32'h0000_1800);
        check_vec("cancel_done1_retrig_dut", dr1, 32'h0000_0000);

        // duration 0, both channels triggered together
        duration = 8'd0;
        run32(32'h0000_0400, 32'h0000_0400, '0, '0);
        check_vec("dur0_en0", ea0, 32'h0000_0800);
        check_vec("dur0_en1", ea1, 32'h0000_0800);
        check_vec("dur0_done0", da0, 32'h0000_1000);
        check_vec("dur0_done1", da1, 32'h0000_1000);
        check_vec("dur0_any", aa, 32'h0000_1000);
        check_vec("dur0_en0_hold_dut", eh0, 32'h0000_0800);

        // edge in the counter==0 cycle (duration 3: edges 10, 13)
        duration = 8'd3;
        run32(32'h0000_2400, '0, '0, '0);
        check_vec("last_edge_retrig_en0", er0, 32'h0001_F800);
        check_vec("last_edge_retrig_done0", dr0, 32'h0002_0000);
        check_vec("last_edge_drop_en0", ea0, 32'h0000_3800);
        check_vec("last_edge_drop_done0", da0, 32'h0000_4000);

        // full-scale duration: exactly 255 enabled cycles, one done
        duration = 8'd255;
        trigger  = 2'b01;
        step();
        trigger  = 2'b00;
        cnt_en   = 0;
        cnt_dn   = 0;
        for (int k = 0; k < 400; k++) begin
            if (en_a[0]) cnt_en++;
            if (dn_a[0]) cnt_dn++;
            step();
        end
        check_vec("maxdur_en_cycles", 32'(cnt_en), 32'd255);
        check_vec("maxdur_done_count", 32'(cnt_dn), 32'd1);

        // asynchronous reset in the 3rd active cycle, trigger held through release
        duration = 8'd5;
        repeat (10) step();
        trigger = 2'b01;
        step();
        step();
        step();
        check_vec("rstmid_pre_en", {31'd0, en_a[0]}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_vec("rstmid_async_en", {26'd0, en_a, en_r, en_h}, 32'd0);
        check_vec("rstmid_async_any", {29'd0, any_a, any_r, any_h}, 32'd0);
        check_vec("rstmid_async_done", {26'd0, dn_a, dn_r, dn_h}, 32'd0);
        step();
        step();
        reset = 1'b0;
        check_vec("rstrel_en_low", {31'd0, en_a[0]}, 32'd0);
        step();
        check_vec("rstrel_en_high", {29'd0, en_a[0], en_r[0], en_h[0]}, 32'd7);
        check_vec("rstrel_no_done", {26'd0, dn_a, dn_r, dn_h}, 32'd0);
        trigger = '0;
        repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
